// File: rtl/pc_fetch_unit_if.sv
// Bus bundle between the fetch unit and its incrementer, instruction memory,
// branch source and decode stage.
interface pc_fetch_unit_if #(
    parameter int PC_WIDTH    = 11,
    parameter int INSTR_WIDTH = 16
);
    logic [PC_WIDTH-1:0]    inc_a;
    logic                   inc_cin;
    logic [PC_WIDTH-1:0]    inc_q;
    logic                   imem_req;
    logic [PC_WIDTH-1:0]    imem_addr;
    logic                   imem_ready;
    logic [INSTR_WIDTH-1:0] imem_rdata;
    logic                   branch_valid;
    logic [PC_WIDTH-1:0]    branch_target;
    logic                   instr_valid;
    logic                   instr_ready;
    logic [INSTR_WIDTH-1:0] instr;
    logic [PC_WIDTH-1:0]    instr_pc;

    modport master (
        output inc_a, inc_cin, imem_req, imem_addr, instr_valid, instr, instr_pc,
        input  inc_q, imem_ready, imem_rdata, branch_valid, branch_target, instr_ready
    );

    modport slave (
        input  inc_a, inc_cin, imem_req, imem_addr, instr_valid, instr, instr_pc,
        output inc_q, imem_ready, imem_rdata, branch_valid, branch_target, instr_ready
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// PC register and instruction-fetch sequencer: one outstanding request,
// one-entry decode slot, redirects that can discard an in-flight fetch.
//
// state | meaning
// IDLE  | no request outstanding; issue when the slot is free
// WAIT  | request outstanding; its response will be captured
// DRAIN | request outstanding but redirected; its response is discarded
module pc_fetch_unit #(
    parameter int                    PC_WIDTH    = 11,
    parameter int                    INSTR_WIDTH = 16,
    parameter logic [PC_WIDTH-1:0]   RESET_PC    = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    pc_fetch_unit_if.master    bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                 state;
    logic [PC_WIDTH-1:0]    pc;
    logic [PC_WIDTH-1:0]    fetch_addr;
    logic                   req;
    logic                   slot_valid;
    logic [INSTR_WIDTH-1:0] slot_instr;
    logic [PC_WIDTH-1:0]    slot_pc;
    logic                   slot_free;

    assign slot_free = !slot_valid || bus.instr_ready;

    assign bus.inc_a       = pc;
    assign bus.inc_cin     = 1'b1;
    assign bus.imem_req    = req;
    assign bus.imem_addr   = fetch_addr;
    assign bus.instr_valid = slot_valid;
    assign bus.instr       = slot_instr;
    assign bus.instr_pc    = slot_pc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            fetch_addr <= RESET_PC;
            req        <= 1'b0;
            slot_valid <= 1'b0;
            slot_instr <= '0;
            slot_pc    <= '0;
        end else begin
            // Consumption clears the slot unless a capture below refills it.
            if (bus.instr_ready) begin
                slot_valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (bus.branch_valid) begin
                        pc         <= bus.branch_target;
                        slot_valid <= 1'b0;
                    end else if (slot_free) begin
                        fetch_addr <= pc;
                        req        <= 1'b1;
                        state      <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.imem_ready) begin
                        req   <= 1'b0;
                        state <= IDLE;
                        if (bus.branch_valid) begin
                            pc         <= bus.branch_target;
                            slot_valid <= 1'b0;
                        end else begin
                            slot_instr <= bus.imem_rdata;
                            slot_pc    <= fetch_addr;
                            slot_valid <= 1'b1;
                            pc         <= bus.inc_q;
                        end
                    end else if (bus.branch_valid) begin
                        pc         <= bus.branch_target;
                        slot_valid <= 1'b0;
                        state      <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (bus.branch_valid) begin
                        pc         <= bus.branch_target;
                        slot_valid <= 1'b0;
                    end
                    if (bus.imem_ready) begin
                        req   <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    req   <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed vector table for the fetch corner cases,
// then randomized traffic checked against a transaction-level fetch model.
module tb_pc_fetch_unit;

    localparam int                PW       = 11;
    localparam int                IW       = 16;
    localparam logic [PW-1:0]     RST_PC   = 11'h000;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    pc_fetch_unit_if #(.PC_WIDTH(PW), .INSTR_WIDTH(IW)) bus ();

    pc_fetch_unit #(.PC_WIDTH(PW), .INSTR_WIDTH(IW), .RESET_PC(RST_PC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Behavioural incrementer: a + cin, modulo 2^PW.
    assign bus.inc_q = bus.inc_a + {{(PW-1){1'b0}}, bus.inc_cin};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic          rst;
        logic          br;
        logic [PW-1:0] bt;
        logic          rdy;
        logic [IW-1:0] rdata;
        logic          irdy;
        logic          e_req;
        logic [PW-1:0] e_addr;
        logic          e_valid;
        logic [IW-1:0] e_instr;
        logic [PW-1:0] e_ipc;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic br, input logic [PW-1:0] bt,
                       input logic rdy, input logic [IW-1:0] rdata, input logic irdy,
                       input logic e_req, input logic [PW-1:0] e_addr, input logic e_valid,
                       input logic [IW-1:0] e_instr, input logic [PW-1:0] e_ipc);
        vec_t v;
        v.rst = rst; v.br = br; v.bt = bt; v.rdy = rdy; v.rdata = rdata; v.irdy = irdy;
        v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
        v.e_instr = e_instr; v.e_ipc = e_ipc;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic rst, input logic br, input logic [PW-1:0] bt,
                         input logic rdy, input logic [IW-1:0] rdata, input logic irdy);
        rst_n             = rst;
        bus.branch_valid  = br;
        bus.branch_target = bt;
        bus.imem_ready    = rdy;
        bus.imem_rdata    = rdata;
        bus.instr_ready   = irdy;
    endtask

    // Transaction-level reference: one outstanding fetch, a poison flag for
    // redirected fetches, and the decode slot contents.
    logic          m_out;
    logic          m_poison;
    logic [PW-1:0] m_pc;
    logic [PW-1:0] m_addr;
    logic          m_valid;
    logic [IW-1:0] m_instr;
    logic [PW-1:0] m_ipc;

    task automatic model_step();
        logic captured;
        logic flushed;
        captured = 1'b0;
        flushed  = 1'b0;
        if (!rst_n) begin
            m_out = 0; m_poison = 0; m_pc = RST_PC; m_addr = RST_PC;
            m_valid = 0; m_instr = '0; m_ipc = '0;
            return;
        end
        if (bus.branch_valid) begin
            flushed = 1'b1;
            if (m_out && !bus.imem_ready) m_poison = 1'b1;
        end
        if (m_out) begin
            if (bus.imem_ready) begin
                m_out = 1'b0;
                if (!m_poison && !bus.branch_valid) begin
                    captured = 1'b1;
                    m_instr  = bus.imem_rdata;
                    m_ipc    = m_addr;
                    m_pc     = m_addr + 11'd1;
                end
                m_poison = 1'b0;
            end
        end else if (!bus.branch_valid && (!m_valid || bus.instr_ready)) begin
            m_out    = 1'b1;
            m_poison = 1'b0;
            m_addr   = m_pc;
        end
        if (flushed) begin
            m_pc    = bus.branch_target;
            m_valid = 1'b0;
        end else if (captured) begin
            m_valid = 1'b1;
        end else if (bus.instr_ready) begin
            m_valid = 1'b0;
        end
    endtask

    initial begin
        logic prev_br;
        n_cmp = 0;
        n_err = 0;
        drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);

        // rst br bt rdy rdata irdy | req addr valid instr ipc
        add(0, 0, 11'h000, 0, 16'h0000, 1,  0, 11'h000, 0, 16'h0000, 11'h000);
        add(1, 0, 11'h000, 1, 16'hA000, 1,  1, 11'h000, 0, 16'h0000, 11'h000);
        add(1, 0, 11'h000, 1, 16'hA000, 1,  0, 11'h000, 1, 16'hA000, 11'h000);
        add(1, 0, 11'h000, 1, 16'h5555, 1,  1, 11'h001, 0, 16'hA000, 11'h000);
        add(1, 0, 11'h000, 1, 16'hA001, 1,  0, 11'h001, 1, 16'hA001, 11'h001);
        add(1, 0, 11'h000, 1, 16'h5555, 1,  1, 11'h002, 0, 16'hA001, 11'h001);
        add(1, 0, 11'h000, 1, 16'hA002, 1,  0, 11'h002, 1, 16'hA002, 11'h002);
        add(1, 0, 11'h000, 1, 16'h5555, 1,  1, 11'h003, 0, 16'hA002, 11'h002);
        add(1, 0, 11'h000, 1, 16'hA003, 1,  0, 11'h003, 1, 16'hA003, 11'h003);
        // decode stalls five cycles: slot holds, no new request
        for (int i = 0; i < 5; i++)
            add(1, 0, 11'h000, 1, 16'h6666, 0,  0, 11'h003, 1, 16'hA003, 11'h003);
        add(1, 0, 11'h000, 0, 16'h6666, 1,  1, 11'h004, 0, 16'hA003, 11'h003);
        // redirect to 123 while memory stalls; late word is discarded
        add(1, 1, 11'h123, 0, 16'h7777, 1,  1, 11'h004, 0, 16'hA003, 11'h003);
        add(1, 0, 11'h000, 0, 16'h7777, 1,  1, 11'h004, 0, 16'hA003, 11'h003);
        add(1, 0, 11'h000, 0, 16'h7777, 1,  1, 11'h004, 0, 16'hA003, 11'h003);
        add(1, 0, 11'h000, 1, 16'hBEEF, 1,  0, 11'h004, 0, 16'hA003, 11'h003);
        add(1, 0, 11'h000, 1, 16'hBEEF, 1,  1, 11'h123, 0, 16'hA003, 11'h003);
        // redirect coincident with the response: word dropped
        add(1, 1, 11'h7FF, 1, 16'hDEAD, 1,  0, 11'h123, 0, 16'hA003, 11'h003);
        add(1, 0, 11'h000, 1, 16'hDEAD, 1,  1, 11'h7FF, 0, 16'hA003, 11'h003);
        add(1, 0, 11'h000, 1, 16'hC7FF, 1,  0, 11'h7FF, 1, 16'hC7FF, 11'h7FF);
        add(1, 0, 11'h000, 0, 16'h0000, 1,  1, 11'h000, 0, 16'hC7FF, 11'h7FF);
        // reset while a fetch is outstanding
        add(0, 0, 11'h000, 1, 16'h9999, 1,  0, 11'h000, 0, 16'h0000, 11'h000);
        add(1, 0, 11'h000, 0, 16'h9999, 1,  1, 11'h000, 0, 16'h0000, 11'h000);
        add(1, 0, 11'h000, 1, 16'h1234, 1,  0, 11'h000, 1, 16'h1234, 11'h000);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].br, vecs[i].bt, vecs[i].rdy, vecs[i].rdata, vecs[i].irdy);
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("vec%0d imem_req", i),    32'(bus.imem_req),    32'(vecs[i].e_req));
            chk($sformatf("vec%0d imem_addr", i),   32'(bus.imem_addr),   32'(vecs[i].e_addr));
            chk($sformatf("vec%0d instr_valid", i), 32'(bus.instr_valid), 32'(vecs[i].e_valid));
            chk($sformatf("vec%0d instr", i),       32'(bus.instr),       32'(vecs[i].e_instr));
            chk($sformatf("vec%0d instr_pc", i),    32'(bus.instr_pc),    32'(vecs[i].e_ipc));
            if (i == 0) chk("inc_cin", 32'(bus.inc_cin), 32'd1);
        end

        // Randomized traffic against the reference model.
        drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
        @(posedge clk);
        model_step();
        prev_br = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            chk($sformatf("rnd%0d imem_req", c),    32'(bus.imem_req),    32'(m_out));
            chk($sformatf("rnd%0d imem_addr", c),   32'(bus.imem_addr),   32'(m_addr));
            chk($sformatf("rnd%0d instr_valid", c), 32'(bus.instr_valid), 32'(m_valid));
            chk($sformatf("rnd%0d instr", c),       32'(bus.instr),       32'(m_instr));
            chk($sformatf("rnd%0d instr_pc", c),    32'(bus.instr_pc),    32'(m_ipc));
            chk($sformatf("rnd%0d inc_a", c),       32'(bus.inc_a),       32'(m_pc));
            prev_br = !prev_br && ($urandom_range(0, 7) == 0);
            drive($urandom_range(0, 99) != 0,
                  prev_br,
                  PW'($urandom),
                  $urandom_range(0, 1) == 1,
                  IW'($urandom),
                  $urandom_range(0, 9) < 7);
            if (c % 500 == 499) drive(1'b1, 1'b1, 11'h7FF, 1'b0, IW'($urandom), 1'b1);
            @(posedge clk);
            model_step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
